// File: rtl/vr_pkg.sv
// Shared types for the valid-ready stream blocks.
package vr_pkg;

    // Packer control: collecting beats, or holding a finished word behind a busy output.
    typedef enum logic {
        FILL,
        PEND
    } vr_packer_state_t;

endpackage

// File: rtl/vr_packer.sv
// Valid-ready width up-converter: packs RATIO narrow beats into one wide word,
// flushing a partial word (with its lane count) when a packet ends early.
module vr_packer
    import vr_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int RATIO = 4,
    parameter int OUT_W = IN_W * RATIO,
    parameter int CNT_W = $clog2(RATIO) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int IDX_W = $clog2(RATIO);

    vr_packer_state_t              state;
    logic [IDX_W-1:0]              idx;
    logic [RATIO-1:0][IN_W-1:0]    acc;
    logic [CNT_W-1:0]              acc_count;
    logic                          acc_last;
    logic                          out_full;

    logic                          in_shake;
    logic                          out_shake;
    logic                          word_done;
    logic                          out_free;
    logic [CNT_W-1:0]              count_next;
    logic [RATIO-1:0][IN_W-1:0]    word_next;

    // Ready depends only on state and controls, so upstream never sees a combinational loop.
    assign in_ready   = ~rst & en & ~sync_rst & (state == FILL);
    assign out_valid  = out_full & en;
    assign in_shake   = in_valid & in_ready;
    assign out_shake  = out_valid & out_ready;
    assign word_done  = in_shake & ((idx == IDX_W'(RATIO - 1)) | in_last);
    assign out_free   = ~out_full | out_shake;
    assign count_next = CNT_W'(idx) + CNT_W'(1);

    // Completed word: earlier lanes from the accumulator, current beat at idx, zeros above.
    always_comb begin
        word_next = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (IDX_W'(i) < idx)
                word_next[i] = acc[i];
            else if (IDX_W'(i) == idx)
                word_next[i] = in_data;
        end
    end

    // Lane accumulation, output register load and FILL/PEND sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            acc       <= '0;
            acc_count <= '0;
            acc_last  <= 1'b0;
            out_full  <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else if (sync_rst) begin
            state     <= FILL;
            idx       <= '0;
            acc       <= '0;
            acc_count <= '0;
            acc_last  <= 1'b0;
            out_full  <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else if (en) begin
            // A drained output empties unless a new word is loaded below (later assignment wins).
            if (out_shake)
                out_full <= 1'b0;
            case (state)
                FILL: begin
                    if (in_shake) begin
                        acc[idx] <= in_data;
                        if (word_done) begin
                            if (out_free) begin
                                out_data  <= word_next;
                                out_count <= count_next;
                                out_last  <= in_last;
                                out_full  <= 1'b1;
                                idx       <= '0;
                            end else begin
                                acc       <= word_next;
                                acc_count <= count_next;
                                acc_last  <= in_last;
                                state     <= PEND;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                PEND: begin
                    if (out_shake) begin
                        out_data  <= acc;
                        out_count <= acc_count;
                        out_last  <= acc_last;
                        out_full  <= 1'b1;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
